// File: rtl/char_column_sequencer_pkg.sv
// Shared definitions for the character column sequencer: glyph codes,
// raster geometry defaults and the sequencing FSM state type.
package char_column_sequencer_pkg;

  localparam int CHAR_W = 6;

  localparam logic [CHAR_W-1:0] CH_BLANK = 6'h00;
  localparam logic [CHAR_W-1:0] CH_0     = 6'h1B;
  localparam logic [CHAR_W-1:0] CH_1     = 6'h1C;
  localparam logic [CHAR_W-1:0] CH_2     = 6'h1D;

  localparam int RASTER_H_ACTIVE = 640;
  localparam int RASTER_V_ACTIVE = 480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_DRAW,
    ST_NEXT
  } seq_state_t;

endpackage

// File: rtl/char_column_sequencer_if.sv
// Raster, host-write and renderer-side signals of the column sequencer.
// master = raster/host/renderer side, slave = the sequencer itself.
interface char_column_sequencer_if
  import char_column_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 5
);
  logic [9:0]        CounterX;
  logic [9:0]        CounterY;
  logic              charDone;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CHAR_W-1:0] wr_data;
  logic              len_wr;
  logic [LEN_W-1:0]  len_data;
  logic [CHAR_W-1:0] chr;
  logic              drCh;
  logic              busy;
  logic              seq_err;

  modport master (
    output CounterX, CounterY, charDone, wr_en, wr_addr, wr_data, len_wr, len_data,
    input  chr, drCh, busy, seq_err
  );

  modport slave (
    input  CounterX, CounterY, charDone, wr_en, wr_addr, wr_data, len_wr, len_data,
    output chr, drCh, busy, seq_err
  );
endinterface

// File: rtl/char_column_sequencer_char_buf.sv
// Character string store: one write port, one registered read port.
// A read and write to the same address on the same edge returns the old code.
module char_buf
  import char_column_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              pixclk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [CHAR_W-1:0] rdata
);
  logic [CHAR_W-1:0] mem [DEPTH];
  logic [CHAR_W-1:0] rdata_p1;

  always_ff @(posedge pixclk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_p1 <= mem[raddr];
  end

  assign rdata = rdata_p1;
endmodule

// File: rtl/char_column_sequencer.sv
// Presents a buffered string as a vertical text column, one glyph per cell,
// strobing drCh at (ORIGIN_X, cellY) and waiting on the renderer's charDone.
module char_column_sequencer
  import char_column_sequencer_pkg::*;
#(
  parameter int MAX_CHARS = 16,
  parameter int ORIGIN_X  = 100,
  parameter int ORIGIN_Y  = 100,
  parameter int CELL_H    = 8,
  parameter int H_ACTIVE  = RASTER_H_ACTIVE,
  parameter int V_ACTIVE  = RASTER_V_ACTIVE
) (
  input logic               pixclk,
  input logic               reset,
  char_column_sequencer_if.slave bus
);
  localparam int AW = $clog2(MAX_CHARS);
  localparam int LW = AW + 1;

  // Keep the column inside the active area even if mis-parameterised.
  localparam int COL_X = (ORIGIN_X < 1) ? 1 :
                         (ORIGIN_X > H_ACTIVE - 8) ? H_ACTIVE - 8 : ORIGIN_X;

  localparam logic [9:0]  TRIG_X = 10'(COL_X - 1);
  localparam logic [9:0]  ORG_Y  = 10'(ORIGIN_Y);
  localparam logic [9:0]  PITCH  = 10'(CELL_H);
  localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);

  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] d);
    logic [LW-1:0] r;
    r = d;
    if (int'(d) > MAX_CHARS) r = LW'(MAX_CHARS);
    return r;
  endfunction

  seq_state_t        state_q, state_d;
  logic [LW-1:0]     len_q, len_s_q, idx_q;
  logic [9:0]        celly_q;
  logic              drch_q, chr_vld_q, seq_err_q, chardone_p1;
  logic [CHAR_W-1:0] rd_data;

  logic              fs, hit, done_rise, timeout, last_cell, set_err;
  logic [LW-1:0]     idx_inc;
  logic [9:0]        celly_nxt;
  logic [10:0]       cell_end_nxt;

  char_buf #(.DEPTH(MAX_CHARS), .AW(AW)) u_buf (
    .pixclk (pixclk),
    .we     (bus.wr_en),
    .waddr  (bus.wr_addr),
    .wdata  (bus.wr_data),
    .re     (state_q == ST_LOAD),
    .raddr  (idx_q[AW-1:0]),
    .rdata  (rd_data)
  );

  always_comb begin
    fs           = (bus.CounterX == 10'd0) && (bus.CounterY == 10'd0);
    hit          = (bus.CounterY == celly_q) && (bus.CounterX == TRIG_X);
    done_rise    = bus.charDone && !chardone_p1;
    timeout      = (bus.CounterY == celly_q + PITCH);
    idx_inc      = idx_q + LW'(1);
    celly_nxt    = celly_q + PITCH;
    cell_end_nxt = {1'b0, celly_nxt} + 11'd8;
    last_cell    = (idx_inc == len_s_q) || (cell_end_nxt > V_LIM);
    set_err      = (state_q == ST_DRAW) && timeout && !done_rise && !fs;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: if (hit) state_d = ST_DRAW;
      ST_DRAW: if (done_rise || timeout) state_d = ST_NEXT;
      ST_NEXT: state_d = last_cell ? ST_IDLE : ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
    // Frame start always wins: normal start from IDLE, or overrun restart.
    if (fs) state_d = (len_q != '0) ? ST_LOAD : ST_IDLE;
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      len_s_q     <= '0;
      idx_q       <= '0;
      drch_q      <= 1'b0;
      chr_vld_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      chardone_p1 <= 1'b0;
    end else begin
      state_q     <= state_d;
      chardone_p1 <= bus.charDone;
      drch_q      <= (state_q == ST_WAIT) && hit && !fs;
      if (bus.len_wr) len_q <= sat_len(bus.len_data);
      if (fs) begin
        len_s_q <= len_q;
        idx_q   <= '0;
      end else if (state_q == ST_NEXT) begin
        idx_q <= idx_inc;
      end
      if (state_q == ST_LOAD) chr_vld_q <= 1'b1;
      if (set_err) seq_err_q <= 1'b1;
    end
  end

  // Cell Y accumulator: seeded at frame start, stepped once per cell.
  always_ff @(posedge pixclk) begin
    if (fs) celly_q <= ORG_Y;
    else if (state_q == ST_NEXT) celly_q <= celly_nxt;
  end

  assign bus.chr     = chr_vld_q ? rd_data : CH_BLANK;
  assign bus.drCh    = drch_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.seq_err = seq_err_q;
endmodule

// File: tb/tb_char_column_sequencer.sv
// Scoreboard bench for char_column_sequencer: a compressed raster (lines 0, 96..126,
// 456..486) drives two instances (column at Y=100 and at Y=460) with a renderer model.
module tb_char_column_sequencer;
  import char_column_sequencer_pkg::*;

  localparam int H_TOT = 110;

  typedef struct {
    int x;
    int y;
    int c;
  } ev_t;

  logic pixclk;
  logic reset;

  char_column_sequencer_if bus1 ();
  char_column_sequencer_if bus2 ();

  char_column_sequencer #(.ORIGIN_Y(100)) dut1 (.pixclk(pixclk), .reset(reset), .bus(bus1));
  char_column_sequencer #(.ORIGIN_Y(460)) dut2 (.pixclk(pixclk), .reset(reset), .bus(bus2));

  ev_t q1[$];
  ev_t q2[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cur_x = 0;
  int  cur_y = 0;
  bit  ren_en1 = 1'b1, ren_en2 = 1'b1;
  bit  act1 = 1'b0, act2 = 1'b0;
  int  cx1 = 0, cy1 = 0, cx2 = 0, cy2 = 0;
  bit  busy_seen1 = 1'b0, busy_seen2 = 1'b0;
  bit  prev_drch1 = 1'b0, prev_drch2 = 1'b0;
  int  prev_chr1 = 0, prev_chr2 = 0;

  initial pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  function automatic int next_y(input int y);
    if (y == 0) return 96;
    if (y == 126) return 456;
    if (y == 486) return 0;
    return y + 1;
  endfunction

  // Renderer: charDone rises once the glyph's last row is past X+7, holds until the next strobe.
  function automatic bit done_model(input bit en, input bit act, input int cx, input int cy,
                                    input int x, input int y);
    return en && act && ((y > cy + 7) || ((y == cy + 7) && (x >= cx + 8)));
  endfunction

  initial begin
    bus1.CounterX = '0; bus1.CounterY = '0; bus1.charDone = 1'b0;
    bus2.CounterX = '0; bus2.CounterY = '0; bus2.charDone = 1'b0;
    forever begin
      @(posedge pixclk);
      #1;
      if (cur_x == H_TOT - 1) begin
        cur_x = 0;
        cur_y = next_y(cur_y);
      end else begin
        cur_x++;
      end
      bus1.CounterX = 10'(cur_x); bus1.CounterY = 10'(cur_y);
      bus2.CounterX = 10'(cur_x); bus2.CounterY = 10'(cur_y);
      bus1.charDone = done_model(ren_en1, act1, cx1, cy1, cur_x, cur_y);
      bus2.charDone = done_model(ren_en2, act2, cx2, cy2, cur_x, cur_y);
    end
  end

  // Output monitor: every drCh pops one expected cell.
  always @(negedge pixclk) begin
    ev_t e;
    if (cur_x == 0 && cur_y == 0) begin
      act1 = 1'b0;
      act2 = 1'b0;
    end
    if (bus1.drCh) begin
      if (prev_drch1) check_val("drch1_width", 1, 0);
      check_val("chr1_setup", int'(bus1.chr), prev_chr1);
      cx1 = cur_x; cy1 = cur_y; act1 = 1'b1;
      if (q1.size() == 0) check_val("drch1_unexpected_y", cur_y, -1);
      else begin
        e = q1.pop_front();
        check_val("drch1_x", cur_x, e.x);
        check_val("drch1_y", cur_y, e.y);
        check_val("drch1_chr", int'(bus1.chr), e.c);
      end
    end
    if (bus2.drCh) begin
      if (prev_drch2) check_val("drch2_width", 1, 0);
      check_val("chr2_setup", int'(bus2.chr), prev_chr2);
      cx2 = cur_x; cy2 = cur_y; act2 = 1'b1;
      if (q2.size() == 0) check_val("drch2_unexpected_y", cur_y, -1);
      else begin
        e = q2.pop_front();
        check_val("drch2_x", cur_x, e.x);
        check_val("drch2_y", cur_y, e.y);
        check_val("drch2_chr", int'(bus2.chr), e.c);
      end
    end
    if (bus1.busy) busy_seen1 = 1'b1;
    if (bus2.busy) busy_seen2 = 1'b1;
    prev_drch1 = bus1.drCh;
    prev_drch2 = bus2.drCh;
    prev_chr1  = int'(bus1.chr);
    prev_chr2  = int'(bus2.chr);
  end

  task automatic wait_xy(input int x, input int y);
    int n;
    n = 0;
    do begin
      @(negedge pixclk);
      n++;
    end while (!(cur_x == x && cur_y == y) && n < 8000);
    if (n >= 8000) check_val("wait_xy_timeout", 0, 1);
  endtask

  task automatic push1(input int y, input int c);
    ev_t e;
    e.x = 100; e.y = y; e.c = c;
    q1.push_back(e);
  endtask

  task automatic push2(input int y, input int c);
    ev_t e;
    e.x = 100; e.y = y; e.c = c;
    q2.push_back(e);
  endtask

  task automatic buf_write(input int a, input int d);
    bus1.wr_en = 1'b1; bus1.wr_addr = 4'(a); bus1.wr_data = 6'(d);
    bus2.wr_en = 1'b1; bus2.wr_addr = 4'(a); bus2.wr_data = 6'(d);
    @(negedge pixclk);
    bus1.wr_en = 1'b0;
    bus2.wr_en = 1'b0;
  endtask

  task automatic len_write1(input int v);
    bus1.len_wr = 1'b1; bus1.len_data = 5'(v);
    @(negedge pixclk);
    bus1.len_wr = 1'b0;
  endtask

  task automatic len_write2(input int v);
    bus2.len_wr = 1'b1; bus2.len_data = 5'(v);
    @(negedge pixclk);
    bus2.len_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0; bus1.len_wr = 1'b0; bus1.len_data = '0;
    bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.len_wr = 1'b0; bus2.len_data = '0;
    repeat (4) @(negedge pixclk);
    check_val("rst_chr", int'(bus1.chr), 0);
    check_val("rst_drch", int'(bus1.drCh), 0);
    check_val("rst_busy", int'(bus1.busy), 0);
    check_val("rst_seq_err", int'(bus1.seq_err), 0);
    reset = 1'b0;

    // Empty string: two quiet frames.
    wait_xy(0, 0);
    busy_seen1 = 1'b0;
    wait_xy(0, 0);
    check_val("t1_f1_busy_seen", int'(busy_seen1), 0);
    busy_seen1 = 1'b0;
    wait_xy(0, 486);
    buf_write(0, 'h1B); buf_write(1, 'h1C); buf_write(2, 'h1D);
    buf_write(3, 'h1B); buf_write(4, 'h1C);
    len_write1(3);
    len_write2(5);
    wait_xy(0, 0);
    check_val("t1_f2_busy_seen", int'(busy_seen1), 0);
    check_val("t1_chr", int'(bus1.chr), 0);

    // Three cells with a cooperating renderer; lower column clipped at the bottom edge.
    push1(100, 'h1B); push1(108, 'h1C); push1(116, 'h1D);
    push2(460, 'h1B); push2(468, 'h1C);
    busy_seen1 = 1'b0; busy_seen2 = 1'b0;
    wait_xy(0, 97);
    len_write2(0);
    wait_xy(0, 0);
    check_val("t2_q1_left", q1.size(), 0);
    check_val("t2_q2_left", q2.size(), 0);
    check_val("t2_busy1_seen", int'(busy_seen1), 1);
    check_val("t2_busy2_seen", int'(busy_seen2), 1);
    check_val("t2_busy1_end", int'(bus1.busy), 0);
    check_val("t2_busy2_end", int'(bus2.busy), 0);
    check_val("t2_seq_err", int'(bus1.seq_err), 0);

    // Silent renderer: every cell times out but the column still advances.
    ren_en1 = 1'b0;
    push1(100, 'h1B); push1(108, 'h1C); push1(116, 'h1D);
    wait_xy(100, 107);
    check_val("t3_seq_err_before", int'(bus1.seq_err), 0);
    wait_xy(5, 108);
    check_val("t3_seq_err_after", int'(bus1.seq_err), 1);
    wait_xy(0, 0);
    check_val("t3_q1_left", q1.size(), 0);
    check_val("t3_busy_end", int'(bus1.busy), 0);
    check_val("t3_seq_err_sticky", int'(bus1.seq_err), 1);
    ren_en1 = 1'b1;

    // Buffer write during cell 0 shows in cell 1; length write lands next frame.
    push1(100, 'h1B); push1(108, 'h1D); push1(116, 'h1D);
    wait_xy(101, 100);
    bus1.wr_en = 1'b1; bus1.wr_addr = 4'd1; bus1.wr_data = 6'h1D;
    bus2.wr_en = 1'b1; bus2.wr_addr = 4'd1; bus2.wr_data = 6'h1D;
    bus1.len_wr = 1'b1; bus1.len_data = 5'd1;
    @(negedge pixclk);
    bus1.wr_en = 1'b0; bus2.wr_en = 1'b0; bus1.len_wr = 1'b0;
    wait_xy(0, 0);
    check_val("t4a_q1_left", q1.size(), 0);
    push1(100, 'h1B);
    wait_xy(0, 486);
    len_write1(3);
    wait_xy(0, 0);
    check_val("t4b_q1_left", q1.size(), 0);
    check_val("t4b_busy_end", int'(bus1.busy), 0);

    // Reset in the middle of cell 1, then a clean restart.
    push1(100, 'h1B); push1(108, 'h1D);
    wait_xy(101, 108);
    reset = 1'b1;
    @(negedge pixclk);
    check_val("t6_drch", int'(bus1.drCh), 0);
    check_val("t6_busy", int'(bus1.busy), 0);
    check_val("t6_chr", int'(bus1.chr), 0);
    check_val("t6_seq_err", int'(bus1.seq_err), 0);
    check_val("t6_q1_left", q1.size(), 0);
    reset = 1'b0;
    len_write1(3);
    wait_xy(0, 0);
    check_val("t6_quiet_rest", q1.size(), 0);
    push1(100, 'h1B); push1(108, 'h1D); push1(116, 'h1D);
    wait_xy(0, 486);
    len_write1(17);
    wait_xy(0, 0);
    check_val("t6b_q1_left", q1.size(), 0);
    check_val("t6b_busy_end", int'(bus1.busy), 0);

    // Oversized length saturates; column runs past the window and overruns into next frame.
    push1(100, 'h1B); push1(108, 'h1D); push1(116, 'h1D); push1(124, 'h1B);
    wait_xy(0, 0);
    check_val("t7_q1_left", q1.size(), 0);
    check_val("t7_busy_overrun", int'(bus1.busy), 1);
    push1(100, 'h1B); push1(108, 'h1D); push1(116, 'h1D); push1(124, 'h1B);
    wait_xy(0, 0);
    check_val("t7b_q1_left", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
